// File: rtl/bus_rr_arbiter_if.sv
// Request/grant handshake and per-master bus payload shared between the
// CPU masters and the round-robin arbiter/mux.
interface bus_rr_arbiter_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        breq_;
    logic [NREQ-1:0]        bgrt_;
    logic [NREQ*ADDR_W-1:0] m_addr;
    logic [NREQ*DATA_W-1:0] m_wdata;
    logic [NREQ-1:0]        m_rw_;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      idata;
    logic                   rw_;
    logic [OWN_W-1:0]       owner;
    logic                   busy;
    logic                   timeout;

    // Master side: drives requests and payloads, observes grants and the shared bus
    modport master (
        output breq_, m_addr, m_wdata, m_rw_,
        input  bgrt_, addr, idata, rw_, owner, busy, timeout
    );

    // Arbiter side: samples requests and payloads, drives grants and the shared bus
    modport slave (
        input  breq_, m_addr, m_wdata, m_rw_,
        output bgrt_, addr, idata, rw_, owner, busy, timeout
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter plus address/data/rw_ mux for the shared devices bus.
// Optional tenure limit enabled by defining ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    bus_rr_arbiter_if.slave  bus
);
    localparam int unsigned OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Reject parameter sets the design does not support
    if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 2) begin : g_cfg_err
        $error("bus_rr_arbiter: unsupported NREQ/MAX_HOLD");
    end

    state_t           state;
    logic [NREQ-1:0]  bgrt_r;
    logic             busy_r;
    logic [OWN_W-1:0] owner_r;
    logic [OWN_W-1:0] last_r;
    logic             timeout_r;

    logic             pick_vld;
    logic [OWN_W-1:0] pick_idx;
    logic [OWN_W-1:0] cand;
    logic             hold_expired;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold;

    assign hold_expired = (hold == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    // Pick the first requester after the last owner, wrapping around
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = OWN_W'((32'(last_r) + k) % NREQ);
            if (!pick_vld && !bus.breq_[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Arbitration FSM with registered grant, busy, owner and timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bgrt_r    <= '1;
            busy_r    <= 1'b0;
            owner_r   <= '0;
            last_r    <= OWN_W'(NREQ - 1);
            timeout_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold      <= '0;
`endif
        end else begin
            timeout_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner_r <= pick_idx;
                        bgrt_r  <= ~(NREQ'(1) << pick_idx);
                        busy_r  <= 1'b1;
                        state   <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold    <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (bus.breq_[owner_r]) begin
                        bgrt_r <= '1;
                        busy_r <= 1'b0;
                        last_r <= owner_r;
                        state  <= TURN;
                    end else if (hold_expired) begin
                        bgrt_r    <= '1;
                        busy_r    <= 1'b0;
                        last_r    <= owner_r;
                        timeout_r <= 1'b1;
                        state     <= TURN;
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        hold <= hold + HOLD_W'(1);
`endif
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Unpack per-master payloads so the owner index selects one directly
    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = bus.m_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = bus.m_wdata[g*DATA_W +: DATA_W];
    end

    // Shared bus mux: owner while busy, otherwise master 0 payload with a forced read
    assign bus.addr  = busy_r ? addr_arr[owner_r]  : addr_arr[0];
    assign bus.idata = busy_r ? wdata_arr[owner_r] : wdata_arr[0];
    assign bus.rw_   = busy_r ? bus.m_rw_[owner_r] : 1'b1;

    assign bus.bgrt_   = bgrt_r;
    assign bus.busy    = busy_r;
    assign bus.owner   = owner_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized self-checking bench for bus_rr_arbiter against a tenure-level
// reference model. Covers the tenure limit when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_bus_rr_arbiter;
    localparam int unsigned NREQ     = 2;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    bus_rr_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_rr_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus copies kept by the bench
    logic [NREQ-1:0]   b_cur;
    logic [ADDR_W-1:0] ma  [NREQ];
    logic [DATA_W-1:0] md  [NREQ];
    logic              mrw [NREQ];
    int                rem [NREQ];

    // Reference model: who holds the bus, whether a turnaround is pending
    int cur;
    int last_m;
    int own_m;
    int tenure;
    bit gap;
    bit to_m;
    int prev_grant;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur    = -1;
        gap    = 1'b0;
        last_m = NREQ - 1;
        own_m  = 0;
        tenure = 0;
        to_m   = 1'b0;
    endtask

    // One clock edge of the arbitration rules, using requests sampled at that edge
    task automatic model_step(input logic [NREQ-1:0] b);
        int n;
        n    = NREQ;
        to_m = 1'b0;
        if (cur >= 0) begin
            if (1'(b >> cur)) begin
                last_m = cur;
                cur    = -1;
                gap    = 1'b1;
            end else if (TO_EN && tenure == MAX_HOLD) begin
                last_m = cur;
                cur    = -1;
                gap    = 1'b1;
                to_m   = 1'b1;
            end else begin
                tenure++;
            end
        end else if (gap) begin
            gap = 1'b0;
        end else begin
            for (int k = 1; k <= n; k++) begin
                int i;
                i = (last_m + k) % n;
                if (cur < 0 && !1'(b >> i)) begin
                    cur    = i;
                    own_m  = i;
                    tenure = 1;
                end
            end
        end
    endtask

    task automatic drive_inputs(input logic [NREQ-1:0] b);
        b_cur     = b;
        bus.breq_ = b;
        for (int i = 0; i < NREQ; i++) begin
            ma[i]  = ADDR_W'($urandom);
            md[i]  = DATA_W'($urandom);
            mrw[i] = 1'($urandom);
            bus.m_addr[i*ADDR_W +: ADDR_W]  = ma[i];
            bus.m_wdata[i*DATA_W +: DATA_W] = md[i];
            bus.m_rw_[i]                    = mrw[i];
        end
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0]   eg;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              er;
        eg = '1;
        ea = ma[0];
        ed = md[0];
        er = 1'b1;
        if (cur >= 0) eg = ~(NREQ'(1) << cur);
        for (int i = 0; i < NREQ; i++) begin
            if (i == cur) begin
                ea = ma[i];
                ed = md[i];
                er = mrw[i];
            end
        end
        chk("bgrt_",   64'(bus.bgrt_),   64'(eg));
        chk("busy",    64'(bus.busy),    64'(cur >= 0));
        chk("owner",   64'(bus.owner),   64'(own_m));
        chk("timeout", 64'(bus.timeout), 64'(to_m));
        chk("addr",    64'(bus.addr),    64'(ea));
        chk("idata",   64'(bus.idata),   64'(ed));
        chk("rw_",     64'(bus.rw_),     64'(er));
    endtask

    // mode 0: fixed request vector, 1: each owner releases after 3 grant cycles, 2: random
    task automatic cycle(input int mode, input logic [NREQ-1:0] b_fix);
        logic [NREQ-1:0] nb;
        @(posedge clk);
        model_step(b_cur);
        #1;
        nb = b_fix;
        if (mode == 1) begin
            nb = '0;
            if (cur >= 0 && tenure >= 3) nb = NREQ'(1) << cur;
        end else if (mode == 2) begin
            nb = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (rem[i] > 0) rem[i]--;
                else if ($urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 8));
                if (rem[i] == 0) nb = nb | (NREQ'(1) << i);
            end
        end
        drive_inputs(nb);
        #1;
        check_outputs();
        if (mode == 1 && cur >= 0 && tenure == 1) begin
            if (prev_grant >= 0) chk("alt_order", 64'(bus.owner), 64'((prev_grant + 1) % NREQ));
            prev_grant = cur;
        end
    endtask

    initial begin
        int waited;
        prev_grant = -1;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        reset = 1'b1;
        drive_inputs('1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset: no grants, forced read, master 0 payload
        for (int c = 0; c < 5; c++) cycle(0, '1);

        // Master 0 alone for four sampled cycles, then released
        for (int c = 0; c < 4; c++) cycle(0, 2'b10);
        for (int c = 0; c < 3; c++) cycle(0, 2'b11);

        // Master 1 alone
        for (int c = 0; c < 3; c++) cycle(0, 2'b01);
        for (int c = 0; c < 3; c++) cycle(0, 2'b11);

        // Both contending, each owner releasing after three grant cycles
        for (int c = 0; c < 40; c++) cycle(1, '0);
        for (int c = 0; c < 3; c++) cycle(0, 2'b11);

        // Both holding requests indefinitely (tenure limit when enabled)
        for (int c = 0; c < 24; c++) cycle(0, 2'b00);
        for (int c = 0; c < 3; c++) cycle(0, 2'b11);

        // Random request traffic
        for (int c = 0; c < 800; c++) cycle(2, '1);
        for (int c = 0; c < 4; c++) cycle(0, 2'b11);

        // Reset in the middle of a master 1 tenure
        waited = 0;
        cycle(0, 2'b01);
        while (cur != 1 && waited < 10) begin
            cycle(0, 2'b01);
            waited++;
        end
        chk("m1_granted_before_reset", 64'(bus.bgrt_), 64'(2'b01));
        #2;
        reset = 1'b1;
        drive_inputs('1);
        #1;
        model_reset();
        check_outputs();
        chk("reset_bgrt_async", 64'(bus.bgrt_), 64'(2'b11));
        chk("reset_owner_async", 64'(bus.owner), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_inputs(2'b00);
        cycle(0, 2'b00);
        chk("post_reset_first_owner", 64'(bus.owner), 64'(0));
        chk("post_reset_first_bgrt", 64'(bus.bgrt_), 64'(2'b10));
        for (int c = 0; c < 10; c++) cycle(0, 2'b00);
        for (int c = 0; c < 3; c++) cycle(0, 2'b11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
